// File: rtl/seq_shifter.sv
// seq_shifter: iterative SLL/SRL/SRA unit with a fixed coarse step plus single-bit steps.
// Latency: accept edge + floor(shamt/STEP) + (shamt mod STEP) edges until out_valid; shamt==0 is valid after the accept edge.
// Backpressure: in_ready is low from accept until the result is taken; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   flush             synchronous abort, highest priority, returns to IDLE
//   in_valid/in_ready request handshake carrying sel, shamt, data_in
//   sel               00=SLL, 01=SRA, 10=SRL, 11=SRA (same decode as the single-cycle shifter)
//   out_valid/out_ready result handshake carrying data_out
//   busy              high whenever an operation is in flight or waiting to be taken
module seq_shifter #(
  parameter int size = 32,
  parameter int STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              sel,
  input  logic [$clog2(size)-1:0] shamt,
  input  logic [size-1:0]         data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [size-1:0]         data_out,
  output logic                    busy
);

  localparam int SW = $clog2(size);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);
  localparam logic [SW-1:0] ONE_W  = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [size-1:0] r_work;      // operand being shifted
  logic [SW-1:0]   r_rem;       // shift distance still to apply
  logic            r_left;      // 1 for SLL, 0 for either right shift
  logic            r_fill;      // bit shifted in at the MSB on right shifts
  logic [size-1:0] r_data_out;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic            w_coarse;
  logic [size-1:0] w_shifted;
  logic [SW-1:0]   w_rem_next;

  // Take the coarse step while at least STEP bits remain, then finish one bit at a time.
  assign w_coarse = (r_rem >= STEP_W);

  always_comb begin
    w_shifted  = r_work;
    w_rem_next = r_rem;
    if (w_coarse) begin
      if (r_left) begin
        w_shifted = {r_work[size-STEP-1:0], {STEP{1'b0}}};
      end else begin
        w_shifted = {{STEP{r_fill}}, r_work[size-1:STEP]};
      end
      w_rem_next = r_rem - STEP_W;
    end else begin
      if (r_left) begin
        w_shifted = {r_work[size-2:0], 1'b0};
      end else begin
        w_shifted = {r_fill, r_work[size-1:1]};
      end
      w_rem_next = r_rem - ONE_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_rem       <= '0;
      r_left      <= 1'b0;
      r_fill      <= 1'b0;
      r_data_out  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      // Abort wins over any handshake this cycle; the last completed result stays on data_out.
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_left     <= (sel == 2'b00);
            // Sign is captured once here so SRA never re-samples the operand.
            r_fill     <= sel[0] & data_in[size-1];
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (shamt == '0) begin
              r_state     <= S_DONE;
              r_data_out  <= data_in;
              r_rem       <= '0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_work  <= data_in;
              r_rem   <= shamt;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state     <= S_DONE;
            r_data_out  <= w_shifted;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rem       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and randomized checks for seq_shifter against a one-line reference shifter.
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_shifter #(.size(32), .STEP(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .shamt     (shamt),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] s, input logic [4:0] a, input logic [31:0] d);
    case (s)
      2'b00:   ref_shift = d << a;
      2'b10:   ref_shift = d >> a;
      default: ref_shift = 32'($signed(d) >>> a);
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] a);
    ref_lat = 1 + int'(a) / 4 + int'(a) % 4;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [1:0] s, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] res, output int lat);
    sel = s; shamt = a; data_in = d; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    res = data_out;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] res;
  int          lat;
  logic        seen_valid;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = 2'b00; shamt = 5'd0; data_in = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_data_out",  data_out,           32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // SLL by 31: 7 coarse + 3 single steps
    run_op(2'b00, 5'd31, 32'h0000_0001, res, lat);
    check("sll31_data", res, 32'h8000_0000);
    check("sll31_lat",  32'(lat), 32'd11);
    take_result();

    // Right shifts of a negative operand by exactly one coarse step
    run_op(2'b01, 5'd4, 32'h8000_00F0, res, lat);
    check("sra4_data", res, 32'hF800_000F);
    check("sra4_lat",  32'(lat), 32'd2);
    take_result();
    run_op(2'b10, 5'd4, 32'h8000_00F0, res, lat);
    check("srl4_data", res, 32'h0800_000F);
    take_result();
    run_op(2'b11, 5'd7, 32'h8000_00F0, res, lat);
    check("sra11_7_data", res, 32'hFF00_0001);
    check("sra11_7_lat",  32'(lat), 32'd5);
    take_result();

    // Zero shift goes straight to DONE
    run_op(2'b10, 5'd0, 32'hDEAD_BEEF, res, lat);
    check("sh0_data",     res, 32'hDEAD_BEEF);
    check("sh0_lat",      32'(lat), 32'd1);
    check("sh0_in_ready", {31'b0, in_ready}, 32'd0);
    check("sh0_busy",     {31'b0, busy},     32'd1);
    take_result();

    // SHIFT-phase outputs, ignored request, then backpressure in DONE
    sel = 2'b00; shamt = 5'd8; data_in = 32'h0000_0001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("shift_in_ready",  {31'b0, in_ready},  32'd0);
    check("shift_busy",      {31'b0, busy},      32'd1);
    check("shift_out_valid", {31'b0, out_valid}, 32'd0);
    check("shift_hold_prev", data_out, 32'hDEAD_BEEF);
    sel = 2'b10; shamt = 5'd1; data_in = 32'hFFFF_FFFF;   // must be ignored
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid0", {31'b0, out_valid}, 32'd1);
    check("bp_data0",  data_out, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_data",  data_out, 32'h0000_0100);
    end
    take_result();
    check("bp_rel_valid",    {31'b0, out_valid}, 32'd0);
    check("bp_rel_in_ready", {31'b0, in_ready},  32'd1);
    check("bp_rel_busy",     {31'b0, busy},      32'd0);
    sel = 2'b01; shamt = 5'd0; data_in = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", {31'b0, out_valid}, 32'd1);
    check("bp_next_data",  data_out, 32'h1234_5678);
    take_result();

    // Flush during SHIFT
    sel = 2'b10; shamt = 5'd13; data_in = 32'hFFFF_0000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy",     {31'b0, busy},      32'd0);
    check("flush_in_ready", {31'b0, in_ready},  32'd1);
    check("flush_valid",    {31'b0, out_valid}, 32'd0);
    check("flush_data",     data_out, 32'h1234_5678);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("flush_no_valid", {31'b0, seen_valid}, 32'd0);

    // Flush beats a request presented in the same cycle
    flush = 1'b1; in_valid = 1'b1; sel = 2'b00; shamt = 5'd0; data_in = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_req_busy",  {31'b0, busy},      32'd0);
    check("flush_req_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset mid-shift
    sel = 2'b00; shamt = 5'd20; data_in = 32'h0000_0003; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'b0, in_ready},  32'd1);
    check("arst_valid",    {31'b0, out_valid}, 32'd0);
    check("arst_busy",     {31'b0, busy},      32'd0);
    check("arst_data",     data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("arst_no_valid", {31'b0, seen_valid}, 32'd0);

    // Random operations with random result stalls
    for (int n = 0; n < 1500; n++) begin
      logic [1:0]  rs;
      logic [4:0]  ra;
      logic [31:0] rd;
      logic [31:0] held;
      int          stall;
      rs = 2'($urandom_range(0, 3));
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      run_op(rs, ra, rd, res, lat);
      check("rnd_data", res, ref_shift(rs, ra, rd));
      check("rnd_lat",  32'(lat), 32'(ref_lat(ra)));
      held  = ref_shift(rs, ra, rd);
      stall = $urandom_range(0, 3);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("rnd_stall_data", data_out, held);
      end
      take_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
